jk_reg_bank: RTL and testbench

Parametrised bank of WIDTH edge-triggered JK flip-flops sharing one clock and one asynchronous active-low reset. It is the multi-bit successor of the single JK flip-flop in the sequential library. It adds per-bit JK control, synchronous up/down counting built on the JK toggle rule, a serial shift mode, parallel load, clock enable and a terminal-count indication. It is intended for control registers, small event counters and serialisers in the sequential primitives set.

---
 rtl/jk_reg_bank.sv | 160 ++++++++++++++++
 tb/tb_jk_reg_bank.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_reg_bank.sv
// jk_reg_bank
//   Bank of WIDTH edge-triggered JK flip-flops on one clock and one
//   asynchronous active-low reset. Every synchronous operation (per-bit JK,
//   up count, down count, serial shift) is expressed as J/K values per bit
//   and then applied through the common JK update rule. Parallel load
//   bypasses the JK rule.
//
//   Optional feature: define JK_BANK_OVF_EN to build the sticky overflow
//   register. Without it, ovf is tied low and ovf_clr is ignored.
//
// Parameters
//   WIDTH      number of flip-flops (2..32)
//   RESET_VAL  value of q while reset_n is low
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   en       enable for JK / count / shift operations
//   mode     00 JK, 01 count up, 10 count down, 11 shift
//   load     synchronous parallel load (beats en and mode)
//   d        parallel load data
//   j, k     per-bit JK inputs, used in mode 00
//   ser_in   serial input shifted into bit 0 in mode 11
//   ovf_clr  clears the sticky overflow flag
//   q        flip-flop state
//   tc       terminal count, combinational from q and mode
//   ovf      sticky wrap flag (JK_BANK_OVF_EN only, else 0)

module jk_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             ser_in,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_UP    = 2'b01,
    MODE_DOWN  = 2'b10,
    MODE_SHIFT = 2'b11
  } mode_t;

  mode_t            op;
  logic [WIDTH-1:0] jv;
  logic [WIDTH-1:0] kv;
  logic [WIDTH-1:0] jk_next;
  logic [WIDTH-1:0] q_next;
  logic             up_carry;
  logic             dn_borrow;

  assign op = mode_t'(mode);

  // Build J/K per bit for the selected mode. Counting uses the classic
  // synchronous-counter rule: a bit toggles when every lower bit is 1 (up)
  // or 0 (down). Shift drives J = wanted value, K = its inverse, which makes
  // each flop behave as a D flop.
  always_comb begin
    jv        = '0;
    kv        = '0;
    up_carry  = 1'b1;
    dn_borrow = 1'b1;
    unique case (op)
      MODE_JK: begin
        jv = j;
        kv = k;
      end
      MODE_UP: begin
        for (int i = 0; i < WIDTH; i++) begin
          jv[i]    = up_carry;
          kv[i]    = up_carry;
          up_carry = up_carry & q[i];
        end
      end
      MODE_DOWN: begin
        for (int i = 0; i < WIDTH; i++) begin
          jv[i]     = dn_borrow;
          kv[i]     = dn_borrow;
          dn_borrow = dn_borrow & ~q[i];
        end
      end
      MODE_SHIFT: begin
        jv = {q[WIDTH-2:0], ser_in};
        kv = ~{q[WIDTH-2:0], ser_in};
      end
      default: begin
        jv = '0;
        kv = '0;
      end
    endcase
  end

  // Common JK update rule, then the load > enable > hold priority.
  always_comb begin
    jk_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({jv[i], kv[i]})
        2'b00:   jk_next[i] = q[i];
        2'b01:   jk_next[i] = 1'b0;
        2'b10:   jk_next[i] = 1'b1;
        default: jk_next[i] = ~q[i];
      endcase
    end
    if (load)
      q_next = d;
    else if (en)
      q_next = jk_next;
    else
      q_next = q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      q <= RESET_VAL;
    else
      q <= q_next;
  end

  // Terminal count only has meaning in the two counting modes.
  always_comb begin
    tc = 1'b0;
    if (op == MODE_UP)
      tc = &q;
    else if (op == MODE_DOWN)
      tc = ~|q;
  end

`ifdef JK_BANK_OVF_EN
  logic wrap;

  assign wrap = en && !load && (op == MODE_UP || op == MODE_DOWN) && tc;

  // Set has priority over clear so a wrap is never lost to a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ovf <= 1'b0;
    else if (wrap)
      ovf <= 1'b1;
    else if (ovf_clr)
      ovf <= 1'b0;
  end
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr;
  assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// tb_jk_reg_bank
//   Scoreboard bench for jk_reg_bank (WIDTH = 8, RESET_VAL = 8'hA5).
//   Each clocked step drives inputs, advances a behavioural model written
//   with plain arithmetic, pushes the expected q/tc/ovf to a queue, and pops
//   and compares after the edge. Scenario tasks add direct checks against
//   the literal values worked out by hand.

module tb_jk_reg_bank;

  localparam int         W    = 8;
  localparam logic [7:0] RVAL = 8'hA5;

  logic         clk;
  logic         reset_n;
  logic         en;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         ser_in;
  logic         ovf_clr;
  logic [W-1:0] q;
  logic         tc;
  logic         ovf;

  typedef struct {
    logic [W-1:0] q;
    logic         tc;
    logic         ovf;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_q;
  logic         m_ovf;
  int           n_checks;
  int           n_fail;

`ifdef JK_BANK_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  jk_reg_bank #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .mode    (mode),
    .load    (load),
    .d       (d),
    .j       (j),
    .k       (k),
    .ser_in  (ser_in),
    .ovf_clr (ovf_clr),
    .q       (q),
    .tc      (tc),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic model_tc(input logic [W-1:0] v, input logic [1:0] md);
    if (md == 2'b01) return (v == 8'hFF);
    if (md == 2'b10) return (v == 8'h00);
    return 1'b0;
  endfunction

  // Drive one operation, update the model, push the expectation, clock it
  // and compare the popped expectation against the DUT just after the edge.
  task automatic step(input logic i_en, input logic [1:0] i_mode, input logic i_load,
                      input logic [W-1:0] i_d, input logic [W-1:0] i_j,
                      input logic [W-1:0] i_k, input logic i_ser, input logic i_clr);
    logic [W-1:0] nq;
    logic         wrap;
    exp_t         e;
    en = i_en; mode = i_mode; load = i_load; d = i_d;
    j = i_j; k = i_k; ser_in = i_ser; ovf_clr = i_clr;
    nq = m_q;
    if (i_load) nq = i_d;
    else if (i_en) begin
      case (i_mode)
        2'b00: for (int b = 0; b < W; b++)
                 case ({i_j[b], i_k[b]})
                   2'b01: nq[b] = 1'b0;
                   2'b10: nq[b] = 1'b1;
                   2'b11: nq[b] = ~m_q[b];
                   default: nq[b] = m_q[b];
                 endcase
        2'b01: nq = m_q + 8'd1;
        2'b10: nq = m_q - 8'd1;
        default: nq = {m_q[W-2:0], i_ser};
      endcase
    end
    wrap = i_en && !i_load && (i_mode == 2'b01 || i_mode == 2'b10) && model_tc(m_q, i_mode);
    if (OVF_ON) begin
      if (wrap) m_ovf = 1'b1;
      else if (i_clr) m_ovf = 1'b0;
    end
    m_q = nq;
    e.q = m_q; e.tc = model_tc(m_q, i_mode); e.ovf = m_ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL scoreboard_empty: no expectation queued");
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (q !== e.q) begin
        n_fail++;
        $display("[TB] FAIL sb_q: got %h expected %h", q, e.q);
      end
      n_checks++;
      if (tc !== e.tc) begin
        n_fail++;
        $display("[TB] FAIL sb_tc: got %b expected %b (q=%h mode=%b)", tc, e.tc, q, mode);
      end
      n_checks++;
      if (ovf !== e.ovf) begin
        n_fail++;
        $display("[TB] FAIL sb_ovf: got %b expected %b", ovf, e.ovf);
      end
    end
  endtask

  task automatic do_load(input logic [W-1:0] v, input logic [1:0] md);
    step(1'b0, md, 1'b1, v, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  // Reset pulse between edges; q and ovf must change before any clock edge.
  task automatic pulse_reset();
    #2;
    reset_n = 1'b0;
    #1;
    m_q = RVAL; m_ovf = 1'b0;
    n_checks++;
    if (q !== RVAL) begin
      n_fail++;
      $display("[TB] FAIL async_reset_q: got %h expected %h", q, RVAL);
    end
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL async_reset_ovf: got %b expected 0", ovf);
    end
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 0; mode = 2'b00; load = 0; d = 0; j = 0; k = 0; ser_in = 0; ovf_clr = 0;
    reset_n = 1'b0;
    #12;
    m_q = RVAL; m_ovf = 1'b0;
    n_checks++;
    if (q !== RVAL || tc !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got q=%h tc=%b ovf=%b expected q=%h tc=0 ovf=0", q, tc, ovf, RVAL);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      step(1'b0, 2'b00, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0);
    n_checks++;
    if (q !== 8'hA5) begin
      n_fail++;
      $display("[TB] FAIL hold_after_reset: got %h expected a5", q);
    end
  endtask

  task automatic test_jk();
    do_load(8'h0F, 2'b00);
    step(1'b1, 2'b00, 1'b0, 8'h00, 8'hF0, 8'h3C, 1'b0, 1'b0);
    n_checks++;
    if (q !== 8'hF3) begin
      n_fail++;
      $display("[TB] FAIL jk_first: got %h expected f3", q);
    end
    step(1'b1, 2'b00, 1'b0, 8'h00, 8'hF0, 8'h3C, 1'b0, 1'b0);
    n_checks++;
    if (q !== 8'hC3) begin
      n_fail++;
      $display("[TB] FAIL jk_second: got %h expected c3", q);
    end
  endtask

  task automatic test_count_up();
    do_load(8'hFE, 2'b01);
    step(1'b1, 2'b01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (q !== 8'hFF || tc !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL up_ff: got q=%h tc=%b expected q=ff tc=1", q, tc);
    end
    step(1'b1, 2'b01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (q !== 8'h00 || tc !== 1'b0 || ovf !== OVF_ON) begin
      n_fail++;
      $display("[TB] FAIL up_wrap: got q=%h tc=%b ovf=%b expected q=00 tc=0 ovf=%b", q, tc, ovf, OVF_ON);
    end
    step(1'b1, 2'b01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b0, 2'b01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ovf_clear: got %b expected 0", ovf);
    end
  endtask

  task automatic test_count_down();
    do_load(8'h01, 2'b10);
    step(1'b1, 2'b10, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (q !== 8'h00 || tc !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL down_zero: got q=%h tc=%b expected q=00 tc=1", q, tc);
    end
    step(1'b1, 2'b10, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b0, 2'b10, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    // Load with en=1 at the terminal count: load wins and must not set ovf.
    do_load(8'h00, 2'b10);
    step(1'b1, 2'b10, 1'b1, 8'h55, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (q !== 8'h55 || ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL load_priority: got q=%h ovf=%b expected q=55 ovf=0", q, ovf);
    end
  endtask

  task automatic test_shift();
    do_load(8'h81, 2'b11);
    step(1'b1, 2'b11, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    step(1'b1, 2'b11, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b1, 2'b11, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (q !== 8'h0D || tc !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL shift_result: got q=%h tc=%b expected q=0d tc=0", q, tc);
    end
  endtask

  task automatic test_async_reset();
    do_load(8'h3F, 2'b01);
    step(1'b1, 2'b01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    pulse_reset();
    step(1'b1, 2'b01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (q !== 8'hA6) begin
      n_fail++;
      $display("[TB] FAIL resume_after_reset: got %h expected a6", q);
    end
    do_load(8'hFF, 2'b01);
    step(1'b1, 2'b01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (ovf !== OVF_ON) begin
      n_fail++;
      $display("[TB] FAIL set_beats_clear: got %b expected %b", ovf, OVF_ON);
    end
    pulse_reset();
    step(1'b0, 2'b01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0, 8'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom), $urandom_range(0, 3) == 0);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_q      = RVAL;
    m_ovf    = 1'b0;
    test_reset();
    test_jk();
    test_count_up();
    test_count_down();
    test_shift();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
